// File: rtl/dual_ram_arb.sv
// Two-port RAM where port A always wins and port B stalls on address
// collisions, replaying its held request until it can complete.
module dual_ram_arb #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int READ_FIRST = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              we_A,
  input  logic [ADDR_W-1:0] addr_A,
  input  logic [DATA_W-1:0] din_A,
  output logic [DATA_W-1:0] dout_A,
  input  logic              we_B,
  input  logic [ADDR_W-1:0] addr_B,
  input  logic [DATA_W-1:0] din_B,
  output logic [DATA_W-1:0] dout_B,
  output logic              busy_B,
  output logic              rd_valid_B,
  output logic [CNT_W-1:0]  coll_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q;
  logic [0:0]        state_d;

  logic              hold_we_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_din_q;

  logic [DATA_W-1:0] dout_a_q;
  logic [DATA_W-1:0] dout_a_d;
  logic [DATA_W-1:0] dout_b_q;
  logic [DATA_W-1:0] dout_b_d;
  logic              rdv_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din;
  logic              coll;
  logic              b_exec;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // While holding, the replayed op replaces whatever B presents.
  always_comb begin
    b_we   = we_B;
    b_addr = addr_B;
    b_din  = din_B;
    if (state_q == HOLD) begin
      b_we   = hold_we_q;
      b_addr = hold_addr_q;
      b_din  = hold_din_q;
    end
  end

  always_comb begin
    coll    = (b_addr == addr_A) && (we_A || b_we);
    b_exec  = !coll;
    state_d = coll ? HOLD : IDLE;
  end

  always_comb begin
    rd_a = mem_q[addr_A];
    rd_b = mem_q[b_addr];
    dout_a_d = rd_a;
    if (READ_FIRST == 0 && we_A) begin
      dout_a_d = din_A;
    end
    dout_b_d = rd_b;
    if (READ_FIRST == 0 && b_we) begin
      dout_b_d = b_din;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (coll && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Writes are blocked during reset so a discarded op cannot land.
  always_ff @(posedge clock) begin
    if (rst) begin
      if (we_A) begin
        mem_q[addr_A] <= din_A;
      end
      if (b_exec && b_we) begin
        mem_q[b_addr] <= b_din;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_we_q   <= 1'b0;
      hold_addr_q <= '0;
      hold_din_q  <= '0;
      dout_a_q    <= '0;
      dout_b_q    <= '0;
      rdv_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q  <= state_d;
      dout_a_q <= dout_a_d;
      rdv_q    <= b_exec;
      cnt_q    <= cnt_d;
      if (b_exec) begin
        dout_b_q <= dout_b_d;
      end
      if (coll) begin
        hold_we_q   <= b_we;
        hold_addr_q <= b_addr;
        hold_din_q  <= b_din;
      end
    end
  end

  assign dout_A     = dout_a_q;
  assign dout_B     = dout_b_q;
  assign busy_B     = (state_q == HOLD);
  assign rd_valid_B = rdv_q;
  assign coll_cnt   = cnt_q;

endmodule

// File: tb/tb_dual_ram_arb.sv
// Bench for dual_ram_arb: hand-written vector table, reset discard
// sequence and randomized traffic against a queue-based reference model.
module tb_dual_ram_arb;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       we_A  = 1'b0;
  logic [9:0] addr_A = '0;
  logic [7:0] din_A  = '0;
  logic       we_B  = 1'b0;
  logic [9:0] addr_B = '0;
  logic [7:0] din_B  = '0;

  logic [7:0]  dA1, dB1, dA0, dB0;
  logic        busy1, rdv1, busy0, rdv0;
  logic [15:0] cnt1;
  logic [2:0]  cnt0;

  always #5 clock = ~clock;

  dual_ram_arb u_rf1 (
    .clock(clock), .rst(rst),
    .we_A(we_A), .addr_A(addr_A), .din_A(din_A), .dout_A(dA1),
    .we_B(we_B), .addr_B(addr_B), .din_B(din_B), .dout_B(dB1),
    .busy_B(busy1), .rd_valid_B(rdv1), .coll_cnt(cnt1)
  );

  dual_ram_arb #(.READ_FIRST(0), .CNT_W(3)) u_rf0 (
    .clock(clock), .rst(rst),
    .we_A(we_A), .addr_A(addr_A), .din_A(din_A), .dout_A(dA0),
    .we_B(we_B), .addr_B(addr_B), .din_B(din_B), .dout_B(dB0),
    .busy_B(busy0), .rd_valid_B(rdv0), .coll_cnt(cnt0)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_cmp = 0;

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] din;
  } bop_t;

  logic [7:0] m_mem [1024];
  bit         m_ok  [1024];
  bop_t       m_q [$];
  int         m_cnt;
  logic [7:0] e_a1, e_a0, e_b1, e_b0;
  bit         v_a1, v_a0, v_b1, v_b0;
  bit         e_busy, e_rdv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt  = 0;
    e_a1 = 8'h00; e_a0 = 8'h00; e_b1 = 8'h00; e_b0 = 8'h00;
    v_a1 = 1; v_a0 = 1; v_b1 = 1; v_b0 = 1;
    e_busy = 0;
    e_rdv  = 0;
  endtask

  // One clock of the arbitration rules, applied to the current inputs.
  task automatic model_step();
    bop_t cur;
    bit   coll;
    if (m_q.size() != 0) begin
      cur = m_q[0];
    end else begin
      cur.we = we_B; cur.addr = addr_B; cur.din = din_B;
    end
    coll = (cur.addr == addr_A) && (we_A || cur.we);
    e_a1 = m_mem[addr_A];
    v_a1 = m_ok[addr_A];
    e_a0 = we_A ? din_A : e_a1;
    v_a0 = we_A ? 1'b1 : v_a1;
    m_q.delete();
    if (coll) begin
      m_q.push_back(cur);
      m_cnt++;
      e_rdv = 0;
    end else begin
      e_b1 = m_mem[cur.addr];
      v_b1 = m_ok[cur.addr];
      e_b0 = cur.we ? cur.din : e_b1;
      v_b0 = cur.we ? 1'b1 : v_b1;
      e_rdv = 1;
      if (cur.we) begin
        m_mem[cur.addr] = cur.din;
        m_ok[cur.addr]  = 1;
      end
    end
    if (we_A) begin
      m_mem[addr_A] = din_A;
      m_ok[addr_A]  = 1;
    end
    e_busy = (m_q.size() != 0);
  endtask

  task automatic check_model();
    int c1, c0;
    c1 = (m_cnt > 65535) ? 65535 : m_cnt;
    c0 = (m_cnt > 7) ? 7 : m_cnt;
    chk("busy rf1", 32'(busy1), 32'(e_busy));
    chk("busy rf0", 32'(busy0), 32'(e_busy));
    chk("rdv rf1", 32'(rdv1), 32'(e_rdv));
    chk("rdv rf0", 32'(rdv0), 32'(e_rdv));
    chk("cnt rf1", 32'(cnt1), c1);
    chk("cnt rf0 sat", 32'(cnt0), c0);
    if (v_a1) chk("doutA rf1", 32'(dA1), 32'(e_a1));
    if (v_a0) chk("doutA rf0", 32'(dA0), 32'(e_a0));
    if (v_b1) chk("doutB rf1", 32'(dB1), 32'(e_b1));
    if (v_b0) chk("doutB rf0", 32'(dB0), 32'(e_b0));
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    n_vec++;
    check_model();
  endtask

  task automatic set(input logic wa, input logic [9:0] aa,
                     input logic [7:0] da, input logic wb,
                     input logic [9:0] ab, input logic [7:0] db);
    we_A = wa; addr_A = aa; din_A = da;
    we_B = wb; addr_B = ab; din_B = db;
  endtask

  task automatic chk_zero(input string tag);
    n_vec++;
    chk({tag, " doutA rf1"}, 32'(dA1), 0);
    chk({tag, " doutB rf1"}, 32'(dB1), 0);
    chk({tag, " busy rf1"}, 32'(busy1), 0);
    chk({tag, " rdv rf1"}, 32'(rdv1), 0);
    chk({tag, " cnt rf1"}, 32'(cnt1), 0);
    chk({tag, " doutA rf0"}, 32'(dA0), 0);
    chk({tag, " doutB rf0"}, 32'(dB0), 0);
    chk({tag, " busy rf0"}, 32'(busy0), 0);
    chk({tag, " rdv rf0"}, 32'(rdv0), 0);
    chk({tag, " cnt rf0"}, 32'(cnt0), 0);
  endtask

  typedef struct {
    logic        wa;
    logic [9:0]  aa;
    logic [7:0]  da;
    logic        wb;
    logic [9:0]  ab;
    logic [7:0]  db;
    logic        cka;
    logic [7:0]  xa;
    logic        ckb;
    logic [7:0]  xb;
    logic        xbusy;
    logic        xrdv;
    logic [15:0] xcnt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      m_mem[i] = 8'h00;
      m_ok[i]  = 0;
    end
    model_reset();

    tbl[0]  = '{1'b1, 10'h3A5, 8'h5C, 1'b0, 10'h000, 8'h00,
                1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
    tbl[1]  = '{1'b0, 10'h3A5, 8'h00, 1'b0, 10'h3A5, 8'h00,
                1'b1, 8'h5C, 1'b1, 8'h5C, 1'b0, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 10'h010, 8'h11, 1'b1, 10'h010, 8'h22,
                1'b0, 8'h00, 1'b1, 8'h5C, 1'b1, 1'b0, 16'd1};
    tbl[3]  = '{1'b1, 10'h020, 8'h33, 1'b1, 10'h010, 8'hFF,
                1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 16'd1};
    tbl[4]  = '{1'b0, 10'h010, 8'h00, 1'b0, 10'h020, 8'h00,
                1'b1, 8'h22, 1'b1, 8'h33, 1'b0, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 10'h020, 8'h00, 1'b0, 10'h020, 8'h00,
                1'b1, 8'h33, 1'b1, 8'h33, 1'b0, 1'b1, 16'd1};
    tbl[6]  = '{1'b1, 10'h030, 8'h01, 1'b0, 10'h030, 8'h00,
                1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 16'd2};
    tbl[7]  = '{1'b1, 10'h030, 8'h02, 1'b1, 10'h040, 8'hAA,
                1'b1, 8'h01, 1'b1, 8'h33, 1'b1, 1'b0, 16'd3};
    tbl[8]  = '{1'b1, 10'h030, 8'h03, 1'b1, 10'h040, 8'hBB,
                1'b1, 8'h02, 1'b1, 8'h33, 1'b1, 1'b0, 16'd4};
    tbl[9]  = '{1'b1, 10'h100, 8'h66, 1'b1, 10'h040, 8'hCC,
                1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b1, 16'd4};
    tbl[10] = '{1'b1, 10'h100, 8'h77, 1'b0, 10'h040, 8'h00,
                1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b1, 16'd4};
    tbl[11] = '{1'b0, 10'h100, 8'h00, 1'b0, 10'h100, 8'h00,
                1'b1, 8'h77, 1'b1, 8'h77, 1'b0, 1'b1, 16'd4};
    tbl[12] = '{1'b0, 10'h3A5, 8'h00, 1'b1, 10'h200, 8'h44,
                1'b1, 8'h5C, 1'b0, 8'h00, 1'b0, 1'b1, 16'd4};
    tbl[13] = '{1'b0, 10'h200, 8'h00, 1'b0, 10'h200, 8'h00,
                1'b1, 8'h44, 1'b1, 8'h44, 1'b0, 1'b1, 16'd4};

    #1;
    chk_zero("por");
    repeat (2) @(negedge clock);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      set(tbl[i].wa, tbl[i].aa, tbl[i].da,
          tbl[i].wb, tbl[i].ab, tbl[i].db);
      step();
      if (tbl[i].cka) chk($sformatf("tbl%0d doutA", i), 32'(dA1), 32'(tbl[i].xa));
      if (tbl[i].ckb) chk($sformatf("tbl%0d doutB", i), 32'(dB1), 32'(tbl[i].xb));
      chk($sformatf("tbl%0d busy", i), 32'(busy1), 32'(tbl[i].xbusy));
      chk($sformatf("tbl%0d rdv", i), 32'(rdv1), 32'(tbl[i].xrdv));
      chk($sformatf("tbl%0d cnt", i), 32'(cnt1), 32'(tbl[i].xcnt));
      if (i == 10) chk("rf0 own write", 32'(dA0), 32'h77);
    end

    // Held B write must be dropped by a reset that arrives mid-hold.
    set(1'b1, 10'h050, 8'h5A, 1'b0, 10'h051, 8'h00);
    step();
    set(1'b0, 10'h050, 8'h00, 1'b1, 10'h050, 8'hAB);
    step();
    chk("hold before rst", 32'(busy1), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async rst");
    model_reset();
    set(1'b0, 10'h000, 8'h00, 1'b0, 10'h001, 8'h00);
    @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    set(1'b0, 10'h050, 8'h00, 1'b0, 10'h060, 8'h00);
    step();
    chk("held write dropped", 32'(dA1), 32'h5A);
    chk("busy after rst", 32'(busy1), 0);

    for (int i = 0; i < 512; i++) begin
      set(1'b1, 10'(i), 8'($urandom), 1'b1, 10'(i + 512), 8'($urandom));
      step();
    end

    for (int i = 0; i < 3000; i++) begin
      logic [9:0] hi;
      hi = ($urandom_range(0, 3) == 0) ? 10'h3F8 : 10'h000;
      set(1'($urandom), hi | 10'($urandom_range(0, 7)), 8'($urandom),
          1'($urandom), 10'($urandom_range(0, 7)), 8'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
